// File: rtl/seq_div_16b.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Division by zero completes in one cycle with Q = all ones, R = A and DivZero flagged.
module seq_div_16b #(
  parameter int WIDTH = 16
) (
  input  logic             Div_i_Clk,
  input  logic             Div_i_Rst,
  input  logic             Div_i_Start,
  input  logic [WIDTH-1:0] Div_i_A,
  input  logic [WIDTH-1:0] Div_i_B,
  output logic             Div_o_Busy,
  output logic             Div_o_Done,
  output logic [WIDTH-1:0] Div_o_Q,
  output logic [WIDTH-1:0] Div_o_R,
  output logic             Div_o_DivZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   wq_q, wq_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               dz_q, dz_d;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   wq_next_s;

  // Next-state and datapath: one subtract-or-restore step per CALC cycle.
  // A non-borrowing trial always has a zero MSB, so the kept remainder fits in WIDTH bits.
  always_comb begin
    state_d   = state_q;
    wq_d      = wq_q;
    div_d     = div_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    shifted_s = {rem_q, wq_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, div_q};
    wq_next_s = wq_q;
    case (state_q)
      S_IDLE: begin
        if (Div_i_Start) begin
          if (Div_i_B != {WIDTH{1'b0}}) begin
            wq_d    = Div_i_A;
            div_d   = Div_i_B;
            rem_d   = {WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b1;
            state_d = S_CALC;
          end else begin
            q_d    = {WIDTH{1'b1}};
            r_d    = Div_i_A;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (!trial_s[WIDTH]) begin
          rem_d     = trial_s[WIDTH-1:0];
          wq_next_s = {wq_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d     = shifted_s[WIDTH-1:0];
          wq_next_s = {wq_q[WIDTH-2:0], 1'b0};
        end
        wq_d  = wq_next_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          q_d     = wq_next_s;
          r_d     = rem_d;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge Div_i_Clk) begin
    if (Div_i_Rst) begin
      state_q <= S_IDLE;
      wq_q    <= {WIDTH{1'b0}};
      div_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wq_q    <= wq_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign Div_o_Busy    = busy_q;
  assign Div_o_Done    = done_q;
  assign Div_o_Q       = q_q;
  assign Div_o_R       = r_q;
  assign Div_o_DivZero = dz_q;

endmodule

// File: tb/tb_seq_div_16b.sv
// Self-checking bench for seq_div_16b: scoreboard of expected results, one task per scenario.
module tb_seq_div_16b;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [15:0] r;
  logic        dz;

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_div_16b dut (
    .Div_i_Clk    (clk),
    .Div_i_Rst    (rst),
    .Div_i_Start  (start),
    .Div_i_A      (a),
    .Div_i_B      (b),
    .Div_o_Busy   (busy),
    .Div_o_Done   (done),
    .Div_o_Q      (q),
    .Div_o_R      (r),
    .Div_o_DivZero(dz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse Start for one cycle; optionally record the expected result.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input bit push);
    res_t e;
    if (ib == 16'h0000) e = {16'hFFFF, ia, 1'b1};
    else                e = {ia / ib, ia % ib, 1'b0};
    if (push) sb.push_back(e);
    a = ia;
    b = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for Done; n = edges waited (-1 on timeout), bcnt = cycles seen busy.
  task automatic wait_done(output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bcnt++;
      tick();
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000;
    tick(); tick();
    rst = 1'b0;
    n_vec++;
    if ({busy, done, q, r, dz} !== 35'h0) begin
      n_err++;
      $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b want all 0", busy, done, q, r, dz);
    end
  endtask

  task automatic test_basic();
    int n, bc;
    res_t e;
    logic [15:0] av[3] = '{16'hF7F8, 16'hE5E1, 16'h1234};
    logic [15:0] bv[3] = '{16'h7961, 16'h0003, 16'h5678};
    res_t        cv[3] = '{{16'h0002, 16'h0536, 1'b0}, {16'h4CA0, 16'h0001, 1'b0},
                           {16'h0000, 16'h1234, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i], 1'b1);
      wait_done(n, bc);
      n_vec++;
      if (n != 16 || bc != 16) begin
        n_err++;
        $display("FAIL basic_latency[%0d] got edges=%0d busy=%0d want 16/16", i, n, bc);
      end
      e = sb.pop_front();
      n_vec++;
      if ({q, r, dz} !== e || e !== cv[i]) begin
        n_err++;
        $display("FAIL basic_result[%0d] got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 i, q, r, dz, cv[i].q, cv[i].r, cv[i].dz);
      end
      tick();
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_done_pulse[%0d] got done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_divzero();
    int n, bc;
    res_t e;
    issue(16'h3F1B, 16'h0000, 1'b1);
    wait_done(n, bc);
    n_vec++;
    if (n != 0 || bc != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL divzero_latency got edges=%0d busy_cycles=%0d want 0/0", n, bc);
    end
    e = sb.pop_front();
    n_vec++;
    if ({q, r, dz} !== e) begin
      n_err++;
      $display("FAIL divzero_result got q=%h r=%h dz=%b want q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || dz !== 1'b1) begin
      n_err++;
      $display("FAIL divzero_hold got done=%b dz=%b want done=0 dz=1", done, dz);
    end
    issue(16'hE5E1, 16'h0003, 1'b1);
    n_vec++;
    if (dz !== 1'b1 || q !== 16'hFFFF) begin
      n_err++;
      $display("FAIL divzero_keep got dz=%b q=%h want dz=1 q=ffff", dz, q);
    end
    wait_done(n, bc);
    e = sb.pop_front();
    n_vec++;
    if ({q, r, dz} !== e || dz !== 1'b0) begin
      n_err++;
      $display("FAIL divzero_clear got q=%h r=%h dz=%b want q=%h r=%h dz=0", q, r, dz, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back();
    int n, bc;
    res_t e;
    issue(16'hF7F8, 16'h7961, 1'b1);
    repeat (5) tick();
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done(n, bc);
    n_vec++;
    if (n != 10) begin
      n_err++;
      $display("FAIL b2b_ignored_timing got edges=%0d want 10", n);
    end
    e = sb.pop_front();
    n_vec++;
    if ({q, r, dz} !== e) begin
      n_err++;
      $display("FAIL b2b_first got q=%h r=%h dz=%b want q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    issue(16'hFFFF, 16'h0001, 1'b1);
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || q !== 16'h0002 || r !== 16'h0536) begin
      n_err++;
      $display("FAIL b2b_accept got busy=%b done=%b q=%h r=%h want 1 0 0002 0536", busy, done, q, r);
    end
    wait_done(n, bc);
    e = sb.pop_front();
    n_vec++;
    if (n != 16 || {q, r, dz} !== e || q !== 16'hFFFF || r !== 16'h0000) begin
      n_err++;
      $display("FAIL b2b_second got edges=%0d q=%h r=%h want 16 ffff 0000", n, q, r);
    end
  endtask

  task automatic test_mid_reset();
    int n, bc, dcnt;
    res_t e;
    issue(16'hE5E1, 16'h0003, 1'b1);
    void'(sb.pop_back());
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({busy, done, q, r, dz} !== 35'h0) begin
      n_err++;
      $display("FAIL midreset_state got busy=%b done=%b q=%h r=%h dz=%b want all 0", busy, done, q, r, dz);
    end
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    n_vec++;
    if (dcnt != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_no_done got done_pulses=%0d busy=%b want 0 0", dcnt, busy);
    end
    issue(16'hF7F8, 16'h7961, 1'b1);
    wait_done(n, bc);
    e = sb.pop_front();
    n_vec++;
    if (n != 16 || {q, r, dz} !== e) begin
      n_err++;
      $display("FAIL midreset_recover got edges=%0d q=%h r=%h dz=%b want 16 q=%h r=%h", n, q, r, dz, e.q, e.r);
    end
  endtask

  task automatic test_random();
    int n, bc, mode;
    res_t e;
    logic [15:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb = 16'h0001;
        1: rb = ra;
        2: ra = 16'h0000;
        3: rb = 16'hFFFF;
        4: rb = 16'h0000;
        5: rb = 16'($urandom_range(1, 15));
        default: ;
      endcase
      issue(ra, rb, 1'b1);
      wait_done(n, bc);
      e = sb.pop_front();
      n_vec++;
      if (n < 0 || {q, r, dz} !== e) begin
        n_err++;
        $display("FAIL rand_result a=%h b=%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 ra, rb, q, r, dz, e.q, e.r, e.dz);
      end
      if (rb != 16'h0000) begin
        n_vec++;
        if (({16'h0, q} * {16'h0, rb} + {16'h0, r}) !== {16'h0, ra} || r >= rb) begin
          n_err++;
          $display("FAIL rand_identity a=%h b=%h got q=%h r=%h", ra, rb, q, r);
        end
      end
      tick();
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL rand_single_done a=%h b=%h got done=%b want 0", ra, rb, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divzero();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
